// File: rtl/rsa_mont.sv
// Bit-serial Montgomery multiplier: o_m = a * b * 2^-256 mod N, one multiplier bit per clock.
// Fixed 257-cycle latency from the accept edge to the one-cycle done pulse.
module rsa_mont (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [255:0] i_N,
  input  logic [255:0] i_a,
  input  logic [255:0] i_b,
  input  logic         i_input_ready,
  output logic [255:0] o_m,
  output logic         o_output_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SUB  = 2'd2
  } state_t;

  state_t       state_r;
  state_t       state_s;
  logic [255:0] n_r;
  logic [255:0] a_r;
  logic [255:0] b_r;
  logic [257:0] m_r;
  logic [7:0]   cnt_r;
  logic [255:0] m_out_r;
  logic         done_r;

  logic [257:0] t1_s;
  logic [257:0] t2_s;
  logic [257:0] m_next_s;
  logic [255:0] diff_s;
  logic [255:0] result_s;

  assign o_m            = m_out_r;
  assign o_output_ready = done_r;

  // Next-state logic for the accept / iterate / correct sequence
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (i_input_ready) begin
          state_s = S_CALC;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CALC: begin
        if (cnt_r == 8'd255) begin
          state_s = S_SUB;
        end else begin
          state_s = S_CALC;
        end
      end
      S_SUB:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // One Montgomery iteration and the final conditional subtraction
  always_comb begin
    t1_s     = m_r + (a_r[cnt_r] ? {2'b00, b_r} : 258'd0);
    t2_s     = t1_s + (t1_s[0] ? {2'b00, n_r} : 258'd0);
    m_next_s = t2_s >> 1;
    // m < 2N, so when m >= N the difference fits in 256 bits
    diff_s   = m_r[255:0] - n_r;
    if (m_r >= {2'b00, n_r}) begin
      result_s = diff_s;
    end else begin
      result_s = m_r[255:0];
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand latch, accumulator, iteration counter and registered outputs
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      n_r     <= 256'd0;
      a_r     <= 256'd0;
      b_r     <= 256'd0;
      m_r     <= 258'd0;
      cnt_r   <= 8'd0;
      m_out_r <= 256'd0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (i_input_ready) begin
            n_r   <= i_N;
            a_r   <= i_a;
            b_r   <= i_b;
            m_r   <= 258'd0;
            cnt_r <= 8'd0;
          end
        end
        S_CALC: begin
          m_r   <= m_next_s;
          cnt_r <= cnt_r + 8'd1;
        end
        S_SUB: begin
          m_out_r <= result_s;
          done_r  <= 1'b1;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_mont.sv
// Self-checking bench for rsa_mont: fixed vectors, randomized operands against a word-level
// Montgomery reduction model, and multi-cycle sequences for latency, back-to-back and reset.
module tb_rsa_mont;

  logic         i_clk;
  logic         i_rst;
  logic [255:0] i_N;
  logic [255:0] i_a;
  logic [255:0] i_b;
  logic         i_input_ready;
  logic [255:0] o_m;
  logic         o_output_ready;

  int checks;
  int errors;

  rsa_mont dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_N            (i_N),
    .i_a            (i_a),
    .i_b            (i_b),
    .i_input_ready  (i_input_ready),
    .o_m            (o_m),
    .o_output_ready (o_output_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [255:0] n;
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] exp;
  } vec_t;

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // REDC at word level: r = (T + k*N) / 2^256 with k = -T * N^-1 mod 2^256
  function automatic logic [255:0] mont_ref(input logic [255:0] n, input logic [255:0] a,
                                            input logic [255:0] b);
    logic [255:0] inv;
    logic [255:0] k;
    logic [511:0] t;
    logic [513:0] s;
    logic [257:0] r;
    inv = 256'd1;
    for (int i = 0; i < 9; i++) inv = inv * (256'd2 - n * inv);
    t = {256'd0, a} * {256'd0, b};
    k = (~t[255:0] + 256'd1) * inv;
    s = {2'b00, t} + ({258'd0, k} * {258'd0, n});
    r = s[513:256];
    if (r >= {2'b00, n}) r = r - {2'b00, n};
    return r[255:0];
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Start one operation, scramble inputs after acceptance, measure latency and pulse width
  task automatic run_op(input string name, input logic [255:0] n, input logic [255:0] a,
                        input logic [255:0] b, input logic [255:0] exp, input logic chk_val);
    int lat;
    logic [255:0] res;
    @(negedge i_clk);
    i_N = n; i_a = a; i_b = b; i_input_ready = 1'b1;
    @(posedge i_clk); #1;
    i_input_ready = 1'b0;
    i_N = rand256(); i_a = rand256(); i_b = rand256();
    lat = 0;
    while (lat < 400) begin
      @(posedge i_clk); #1;
      lat++;
      if (o_output_ready) break;
    end
    res = o_m;
    check({name, " latency"}, 256'(lat), 256'd257);
    if (chk_val) check({name, " result"}, res, exp);
    @(posedge i_clk); #1;
    check({name, " pulse_low"}, {255'd0, o_output_ready}, 256'd0);
    check({name, " hold"}, o_m, res);
  endtask

  initial begin
    vec_t         vecs[4];
    logic [255:0] n, a, b, n2, a2, b2;
    int           pulses;
    int           c1, c2;
    logic [255:0] r1, r2;
    int           cyc;

    checks = 0;
    errors = 0;

    vecs[0] = '{256'd13, 256'd3, 256'd5, 256'd5};
    vecs[1] = '{256'd13, 256'd3, 256'd3, 256'd3};
    vecs[2] = '{256'd13, 256'd0, 256'd7, 256'd0};
    vecs[3] = '{{256{1'b1}}, {{255{1'b1}}, 1'b0}, {{255{1'b1}}, 1'b0}, 256'd1};

    // Reset with random inputs applied
    i_rst = 1'b0;
    i_N = rand256(); i_a = rand256(); i_b = rand256(); i_input_ready = 1'b1;
    #7;
    check("reset o_m", o_m, 256'd0);
    check("reset ready", {255'd0, o_output_ready}, 256'd0);
    @(negedge i_clk);
    i_input_ready = 1'b0;
    i_rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge i_clk); #1;
      if (o_output_ready) pulses++;
    end
    check("idle no pulse", 256'(pulses), 256'd0);

    // Fixed vectors
    for (int i = 0; i < 4; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].n, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
    end

    // Randomized operands against the reference model
    for (int i = 0; i < 6; i++) begin
      n = rand256();
      if (i[0]) n = n >> $urandom_range(200, 1);
      n[0] = 1'b1;
      if (n < 256'd3) n = 256'd3;
      a = rand256() % n;
      b = rand256() % n;
      run_op($sformatf("rand%0d", i), n, a, b, mont_ref(n, a, b), 1'b1);
    end

    // Even modulus: value unspecified, latency still fixed
    run_op("even_n", 256'd100, 256'd7, 256'd9, 256'd0, 1'b0);

    // Back-to-back with i_input_ready held high and operands changing during the operation
    n = rand256(); n[0] = 1'b1; a = rand256() % n; b = rand256() % n;
    n2 = rand256() >> 3; n2[0] = 1'b1; a2 = rand256() % n2; b2 = rand256() % n2;
    @(negedge i_clk);
    i_N = n; i_a = a; i_b = b; i_input_ready = 1'b1;
    @(posedge i_clk); #1;
    i_N = n2; i_a = a2; i_b = b2;
    c1 = 0; c2 = 0; r1 = '0; r2 = '0;
    for (cyc = 1; cyc <= 530; cyc++) begin
      @(posedge i_clk); #1;
      if (o_output_ready) begin
        if (c1 == 0) begin
          c1 = cyc; r1 = o_m;
        end else begin
          c2 = cyc; r2 = o_m;
          i_input_ready = 1'b0;
          break;
        end
      end
    end
    i_input_ready = 1'b0;
    check("b2b first edge", 256'(c1), 256'd257);
    check("b2b first result", r1, mont_ref(n, a, b));
    check("b2b second edge", 256'(c2), 256'd515);
    check("b2b second result", r2, mont_ref(n2, a2, b2));
    // Let a possible stray third operation drain before the next test
    repeat (300) @(posedge i_clk);

    // Reset at iteration 100
    n = rand256(); n[0] = 1'b1; a = rand256() % n; b = rand256() % n;
    @(negedge i_clk);
    i_N = n; i_a = a; i_b = b; i_input_ready = 1'b1;
    @(posedge i_clk); #1;
    i_input_ready = 1'b0;
    repeat (100) @(posedge i_clk);
    #2;
    i_rst = 1'b0;
    #1;
    check("midreset o_m", o_m, 256'd0);
    check("midreset ready", {255'd0, o_output_ready}, 256'd0);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge i_clk); #1;
      if (o_output_ready) pulses++;
    end
    check("midreset no pulse", 256'(pulses), 256'd0);
    run_op("after_reset", n, a, b, mont_ref(n, a, b), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
